// File: rtl/db_key_extract.sv
// Passive tap on a 64-bit Ethernet/IPv4/UDP receive stream: one 96-bit lookup key per qualifying frame.
// Define DB_KEY_STATS_EN to add saturating rx/key/skip frame counters.
module db_key_extract #(
    parameter int                   DATA_W    = 64,
    parameter int                   KEY_SIZE  = 96,
    parameter int                   FLAG_SIZE = 4,
    parameter logic [FLAG_SIZE-1:0] OP_LOOKUP = 4'h1,
    parameter int                   CNT_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     s_tdata,
    input  logic [DATA_W/8-1:0]   s_tkeep,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic [KEY_SIZE-1:0]   key_out,
    output logic [FLAG_SIZE-1:0]  flag_out,
    output logic                  key_valid
`ifdef DB_KEY_STATS_EN
    ,
    output logic [CNT_W-1:0]      stat_rx,
    output logic [CNT_W-1:0]      stat_key,
    output logic [CNT_W-1:0]      stat_skip
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_B1   = 3'd1,
        ST_B2   = 3'd2,
        ST_B3   = 3'd3,
        ST_B4   = 3'd4,
        ST_SKIP = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            src_ip_q, src_ip_d;
    logic [15:0]            dst_hi_q, dst_hi_d;
    logic [KEY_SIZE-1:0]    key_q, key_d;
    logic [FLAG_SIZE-1:0]   flag_q, flag_d;
    logic                   kv_q, kv_d;
    logic                   key_done_q, key_done_d;

    logic beat, frame_end;
    logic hdr_eth_ok, hdr_proto_ok, tail_keep_ok;
    logic cap_ip, emit, skip_evt;
    logic unused_keep;

    assign s_tready     = 1'b1;
    assign beat         = s_tvalid;
    assign frame_end    = s_tvalid & s_tlast;
    // Header fields as they fall on the 64-bit beat grid (byte 0 on the MSB lane).
    assign hdr_eth_ok   = (s_tdata[31:16] == 16'h0800) && (s_tdata[15:8] == 8'h45);
    assign hdr_proto_ok = (s_tdata[7:0] == 8'd17);
    assign tail_keep_ok = &s_tkeep[7:2];
    assign unused_keep  = ^s_tkeep[1:0];

    assign key_out   = key_q;
    assign flag_out  = flag_q;
    assign key_valid = kv_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            src_ip_q   <= '0;
            dst_hi_q   <= '0;
            key_q      <= '0;
            flag_q     <= '0;
            kv_q       <= 1'b0;
            key_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_ip_q   <= src_ip_d;
            dst_hi_q   <= dst_hi_d;
            key_q      <= key_d;
            flag_q     <= flag_d;
            kv_q       <= kv_d;
            key_done_q <= key_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (beat) begin
            case (state_q)
                ST_IDLE: state_d = s_tlast ? ST_IDLE : ST_B1;
                ST_B1: begin
                    if (s_tlast)          state_d = ST_IDLE;
                    else if (!hdr_eth_ok) state_d = ST_SKIP;
                    else                  state_d = ST_B2;
                end
                ST_B2: begin
                    if (s_tlast)            state_d = ST_IDLE;
                    else if (!hdr_proto_ok) state_d = ST_SKIP;
                    else                    state_d = ST_B3;
                end
                ST_B3:   state_d = s_tlast ? ST_IDLE : ST_B4;
                ST_B4:   state_d = s_tlast ? ST_IDLE : ST_SKIP;
                ST_SKIP: state_d = s_tlast ? ST_IDLE : ST_SKIP;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A frame that already produced its key may still trail beats through SKIP; that end is not a skip.
    always_comb begin
        cap_ip   = beat && (state_q == ST_B3);
        emit     = beat && (state_q == ST_B4) && tail_keep_ok;
        skip_evt = frame_end && !emit && !((state_q == ST_SKIP) && key_done_q);
    end

    always_comb begin
        src_ip_d   = src_ip_q;
        dst_hi_d   = dst_hi_q;
        key_d      = key_q;
        flag_d     = flag_q;
        kv_d       = emit;
        key_done_d = key_done_q;
        if (cap_ip) begin
            src_ip_d = s_tdata[47:16];
            dst_hi_d = s_tdata[15:0];
        end
        if (emit) begin
            key_d  = {src_ip_q, dst_hi_q, s_tdata[63:48], s_tdata[31:16], 16'h0000};
            flag_d = OP_LOOKUP;
        end
        if (frame_end)
            key_done_d = 1'b0;
        else if (emit)
            key_done_d = 1'b1;
    end

`ifdef DB_KEY_STATS_EN
    logic [CNT_W-1:0] stat_rx_q, stat_rx_d;
    logic [CNT_W-1:0] stat_key_q, stat_key_d;
    logic [CNT_W-1:0] stat_skip_q, stat_skip_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && !(&v))
            return v + CNT_W'(1);
        return v;
    endfunction

    always_comb begin
        stat_rx_d   = sat_inc(stat_rx_q, frame_end);
        stat_key_d  = sat_inc(stat_key_q, kv_q);
        stat_skip_d = sat_inc(stat_skip_q, skip_evt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_rx_q   <= '0;
            stat_key_q  <= '0;
            stat_skip_q <= '0;
        end else begin
            stat_rx_q   <= stat_rx_d;
            stat_key_q  <= stat_key_d;
            stat_skip_q <= stat_skip_d;
        end
    end

    assign stat_rx   = stat_rx_q;
    assign stat_key  = stat_key_q;
    assign stat_skip = stat_skip_q;
`else
    logic unused_skip;
    assign unused_skip = skip_evt;
`endif

endmodule

// File: tb/tb_db_key_extract.sv
// Bench for db_key_extract: table of directed frames, hand sequences for reset, then random frames
// checked against a byte-offset model of the Ethernet/IPv4/UDP header.
module tb_db_key_extract;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [95:0] key_out;
    logic [3:0]  flag_out;
    logic        key_valid;
`ifdef DB_KEY_STATS_EN
    logic [31:0] stat_rx, stat_key, stat_skip;
    int exp_rx = 0, exp_keys = 0, exp_skip = 0;
`endif

    db_key_extract dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready),
        .key_out(key_out), .flag_out(flag_out), .key_valid(key_valid)
`ifdef DB_KEY_STATS_EN
        , .stat_rx(stat_rx), .stat_key(stat_key), .stat_skip(stat_skip)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [63:0] fb [16];
    logic [7:0]  fk [16];
    int          fn;
    logic [95:0] last_key = '0;
    logic [3:0]  last_flag = '0;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] dport;
        logic [7:0]  proto;
        logic [15:0] etype;
        logic [7:0]  verihl;
        int          nbeats;
        logic [7:0]  keep4;
        int          gap_at;
        int          gap_len;
        logic        exp_kv;
        logic [95:0] exp_key;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] dport,
                           input logic [7:0] proto, input logic [15:0] etype, input logic [7:0] verihl,
                           input int nbeats, input logic [7:0] keep4, input int gap_at, input int gap_len,
                           input logic exp_kv, input logic [95:0] exp_key);
        vec_t v;
        v.src = src; v.dst = dst; v.dport = dport; v.proto = proto; v.etype = etype;
        v.verihl = verihl; v.nbeats = nbeats; v.keep4 = keep4; v.gap_at = gap_at;
        v.gap_len = gap_len; v.exp_kv = exp_kv; v.exp_key = exp_key;
        vecs.push_back(v);
    endtask

    task automatic build_frame(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] dport,
                               input logic [7:0] proto, input logic [15:0] etype, input logic [7:0] verihl,
                               input int nbeats, input logic [7:0] keep4);
        logic [7:0] by [128];
        for (int i = 0; i < 128; i++) by[i] = 8'($urandom);
        {by[12], by[13]} = etype;
        by[14] = verihl;
        by[23] = proto;
        {by[26], by[27], by[28], by[29]} = src;
        {by[30], by[31], by[32], by[33]} = dst;
        {by[36], by[37]} = dport;
        fn = nbeats;
        for (int b = 0; b < 16; b++) begin
            for (int k = 0; k < 8; k++) fb[b][63-8*k -: 8] = by[8*b+k];
            fk[b] = 8'hFF;
        end
        fk[4] = keep4;
    endtask

    function automatic logic [7:0] fbyte(input int i);
        return fb[i/8][63-8*(i%8) -: 8];
    endfunction

    // A frame qualifies on header content alone: at least 5 beats, IPv4 with a 20-byte header,
    // UDP, and bytes 32..37 (rest of dst IP and dst port) all present.
    function automatic logic model_key(output logic [95:0] key);
        logic ok;
        ok = (fn >= 5) && ({fbyte(12), fbyte(13)} == 16'h0800) && (fbyte(14) == 8'h45)
             && (fbyte(23) == 8'd17);
        for (int k = 32; k < 38; k++)
            if (!fk[k/8][7-(k%8)]) ok = 1'b0;
        key = {fbyte(26), fbyte(27), fbyte(28), fbyte(29), fbyte(30), fbyte(31),
               fbyte(32), fbyte(33), fbyte(36), fbyte(37), 16'h0000};
        return ok;
    endfunction

    task automatic tick(input logic exp_kv, input logic [95:0] exp_key);
        @(posedge clk);
        #1;
        chk("key_valid", key_valid, exp_kv);
        if (exp_kv) begin
            chk("key_out", key_out, exp_key);
            chk("flag_out", flag_out, 4'h1);
        end
    endtask

    task automatic idle_cycle();
        s_tvalid = 1'b0;
        s_tdata  = {$urandom, $urandom};
        s_tkeep  = 8'($urandom);
        s_tlast  = 1'($urandom);
        tick(1'b0, '0);
    endtask

    task automatic send_frame(input int rand_gap, input int gap_at, input int gap_len,
                              input logic exp_kv, input logic [95:0] exp_key);
        logic kv;
        for (int b = 0; b < fn; b++) begin
            if (b == gap_at) repeat (gap_len) idle_cycle();
            if (rand_gap > 0) repeat ($urandom_range(0, rand_gap)) idle_cycle();
            s_tvalid = 1'b1;
            s_tdata  = fb[b];
            s_tkeep  = fk[b];
            s_tlast  = (b == fn - 1);
            kv = (b == 4) && exp_kv;
            if (kv) begin
                last_key  = exp_key;
                last_flag = 4'h1;
            end
            tick(kv, exp_key);
        end
        s_tvalid = 1'b0;
        chk("key_hold", key_out, last_key);
        chk("flag_hold", flag_out, last_flag);
`ifdef DB_KEY_STATS_EN
        exp_rx++;
        if (exp_kv) exp_keys++; else exp_skip++;
`endif
    endtask

`ifdef DB_KEY_STATS_EN
    task automatic check_stats();
        idle_cycle();
        chk("stat_rx", stat_rx, 32'(exp_rx));
        chk("stat_key", stat_key, 32'(exp_keys));
        chk("stat_skip", stat_skip, 32'(exp_skip));
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [95:0] mkey;
        logic        mok;
        logic [31:0] r_src, r_dst;
        logic [15:0] r_dport, r_etype;
        logic [7:0]  r_proto, r_verihl, r_keep4;
        int          r_n;

        rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_key_valid", key_valid, 1'b0);
        chk("rst_key_out", key_out, 96'h0);
        chk("rst_flag_out", flag_out, 4'h0);
        chk("rst_tready", s_tready, 1'b1);
`ifdef DB_KEY_STATS_EN
        chk("rst_stat_skip", stat_skip, 32'h0);
`endif
        #2 rst = 1'b0;

        //       src            dst            dport    proto  etype     verihl n  keep4  gap_at len kv    key
        add_vec(32'h0A000001, 32'hC0A80102, 16'd53,   8'd17, 16'h0800, 8'h45, 6, 8'hFF, -1, 0, 1'b1, 96'h0A000001_C0A80102_0035_0000);
        add_vec(32'h0A000001, 32'hC0A80102, 16'd53,   8'd17, 16'h86DD, 8'h45, 6, 8'hFF, -1, 0, 1'b0, '0);
        add_vec(32'h0A000001, 32'hC0A80102, 16'd80,   8'd6,  16'h0800, 8'h45, 6, 8'hFF, -1, 0, 1'b0, '0);
        add_vec(32'hC0A80001, 32'h0A0A0A0A, 16'h04D2, 8'd17, 16'h0800, 8'h45, 5, 8'hFF, -1, 0, 1'b1, 96'hC0A80001_0A0A0A0A_04D2_0000);
        add_vec(32'h01010101, 32'h02020202, 16'd7,    8'd17, 16'h0800, 8'h45, 3, 8'hFF, -1, 0, 1'b0, '0);
        add_vec(32'h01020304, 32'h05060708, 16'hFFFF, 8'd17, 16'h0800, 8'h45, 5, 8'hFF, -1, 0, 1'b1, 96'h01020304_05060708_FFFF_0000);
        add_vec(32'h0A000001, 32'hC0A80102, 16'd53,   8'd17, 16'h0800, 8'h45, 6, 8'hFF,  3, 3, 1'b1, 96'h0A000001_C0A80102_0035_0000);
        add_vec(32'h0A000001, 32'hC0A80102, 16'd53,   8'd17, 16'h0800, 8'h46, 6, 8'hFF, -1, 0, 1'b0, '0);
        add_vec(32'hAABBCCDD, 32'h11223344, 16'h1111, 8'd17, 16'h0800, 8'h45, 5, 8'hF8, -1, 0, 1'b0, '0);
        add_vec(32'hAABBCCDD, 32'h11223344, 16'h2222, 8'd17, 16'h0800, 8'h45, 6, 8'hFC, -1, 0, 1'b1, 96'hAABBCCDD_11223344_2222_0000);
        add_vec(32'h0A000001, 32'hC0A80102, 16'd53,   8'd17, 16'h0800, 8'h45, 1, 8'hFF, -1, 0, 1'b0, '0);
        add_vec(32'h0A000001, 32'hC0A80102, 16'd53,   8'd17, 16'h0800, 8'h45, 4, 8'hFF, -1, 0, 1'b0, '0);
        add_vec(32'hDEADBEEF, 32'hCAFEF00D, 16'h8001, 8'd17, 16'h0800, 8'h45, 8, 8'hFF,  2, 1, 1'b1, 96'hDEADBEEF_CAFEF00D_8001_0000);

        foreach (vecs[i]) begin
            build_frame(vecs[i].src, vecs[i].dst, vecs[i].dport, vecs[i].proto, vecs[i].etype,
                        vecs[i].verihl, vecs[i].nbeats, vecs[i].keep4);
            send_frame(0, vecs[i].gap_at, vecs[i].gap_len, vecs[i].exp_kv, vecs[i].exp_key);
        end
`ifdef DB_KEY_STATS_EN
        check_stats();
`endif

        // Asynchronous reset while beat 3 of a good frame is on the bus.
        build_frame(32'h0A000001, 32'hC0A80102, 16'd53, 8'd17, 16'h0800, 8'h45, 6, 8'hFF);
        for (int b = 0; b < 3; b++) begin
            s_tvalid = 1'b1; s_tdata = fb[b]; s_tkeep = fk[b]; s_tlast = 1'b0;
            tick(1'b0, '0);
        end
        s_tdata = fb[3]; s_tkeep = fk[3];
        #2 rst = 1'b1;
        #1;
        chk("arst_key_valid", key_valid, 1'b0);
        chk("arst_key_out", key_out, 96'h0);
        chk("arst_flag_out", flag_out, 4'h0);
        chk("arst_tready", s_tready, 1'b1);
        s_tvalid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        last_key = '0; last_flag = '0;
`ifdef DB_KEY_STATS_EN
        exp_rx = 0; exp_keys = 0; exp_skip = 0;
`endif
        build_frame(32'h0A000002, 32'hC0A80103, 16'd5353, 8'd17, 16'h0800, 8'h45, 5, 8'hFF);
        send_frame(0, -1, 0, 1'b1, 96'h0A000002_C0A80103_14E9_0000);

        for (int f = 0; f < 60; f++) begin
            r_src    = $urandom;
            r_dst    = $urandom;
            r_dport  = 16'($urandom);
            r_etype  = ($urandom_range(0, 4) == 0) ? 16'h86DD : 16'h0800;
            r_verihl = ($urandom_range(0, 5) == 0) ? 8'h46 : 8'h45;
            r_proto  = ($urandom_range(0, 4) == 0) ? 8'd6 : 8'd17;
            r_n      = int'($urandom_range(1, 9));
            r_keep4  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            build_frame(r_src, r_dst, r_dport, r_proto, r_etype, r_verihl, r_n, r_keep4);
            mok = model_key(mkey);
            send_frame(2, -1, 0, mok, mkey);
        end
`ifdef DB_KEY_STATS_EN
        check_stats();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
